// File: rtl/mac_port_table_if.sv
// Lookup and learn bus of the MAC-to-port table.
interface mac_port_table_if #(
  parameter int unsigned NETH = 4,
  parameter int unsigned MACW = 48
);
  logic            TBL_REQUEST;
  logic [MACW-1:0] TBL_MAC;
  logic            TBL_VALID;
  logic [NETH-1:0] TBL_PORT;
  logic            LEARN_VALID;
  logic            LEARN_READY;
  logic [MACW-1:0] LEARN_MAC;
  logic [NETH-1:0] LEARN_PORT;

  modport master (
    output TBL_REQUEST, TBL_MAC, LEARN_VALID, LEARN_MAC, LEARN_PORT,
    input  TBL_VALID, TBL_PORT, LEARN_READY
  );

  modport slave (
    input  TBL_REQUEST, TBL_MAC, LEARN_VALID, LEARN_MAC, LEARN_PORT,
    output TBL_VALID, TBL_PORT, LEARN_READY
  );
endinterface

// File: rtl/mac_port_table.sv
// MAC-to-port forwarding table: sequential lookup, source learning with
// match / first-free / round-robin replacement.
// Optional entry aging is enabled by defining MAC_PORT_TABLE_AGING_EN.
module mac_port_table #(
  parameter int unsigned NETH  = 4,
  parameter int unsigned MACW  = 48,
  parameter int unsigned LGTBL = 4,
  parameter int unsigned LGAGE = 24
) (
  input logic              i_clk,
  input logic              i_reset,
  mac_port_table_if.slave  bus
);

  localparam int unsigned N = 1 << LGTBL;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LSEARCH = 3'd1;
  localparam logic [2:0] S_LRESP   = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_WSEARCH = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [LGTBL-1:0] idx_q, idx_d;
  logic [LGTBL-1:0] rr_q, rr_d;
  logic [MACW-1:0]  key_q, key_d;
  logic [NETH-1:0]  lport_q, lport_d;
  logic             valid_out_q, valid_out_d;
  logic [NETH-1:0]  port_out_q, port_out_d;
  logic             mfound_q, mfound_d;
  logic [LGTBL-1:0] midx_q, midx_d;
  logic             ifound_q, ifound_d;
  logic [LGTBL-1:0] iidx_q, iidx_d;

  logic [N-1:0]     tbl_v_q, tbl_v_d;
  logic [MACW-1:0]  tbl_mac_q [N];
  logic [MACW-1:0]  tbl_mac_d [N];
  logic [NETH-1:0]  tbl_port_q [N];
  logic [NETH-1:0]  tbl_port_d [N];

  logic             cur_hit;
  logic             idx_last;
  logic             learn_ready_c;
  logic             sweep_pend_c;

`ifdef MAC_PORT_TABLE_AGING_EN
  logic [N-1:0]     age_q, age_d;
  logic [LGAGE-1:0] age_cnt_q, age_cnt_d;
  logic             pend_q, pend_d;
  logic             wrap_c;

  assign wrap_c       = &age_cnt_q;
  assign sweep_pend_c = pend_q;
`else
  assign sweep_pend_c = 1'b0;
  // Aging period has no effect when aging is compiled out.
  if (LGAGE == 0) begin : g_no_age
  end
`endif

  assign cur_hit  = tbl_v_q[idx_q] && (tbl_mac_q[idx_q] == key_q);
  assign idx_last = (idx_q == LGTBL'(N - 1));

  // Learning only when idle and no lookup or sweep is waiting.
  assign learn_ready_c = !i_reset && (state_q == S_IDLE) && !bus.TBL_REQUEST && !sweep_pend_c;

  assign bus.TBL_VALID   = valid_out_q;
  assign bus.TBL_PORT    = port_out_q;
  assign bus.LEARN_READY = learn_ready_c;

  // Next-state, table update and response logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    key_d       = key_q;
    lport_d     = lport_q;
    valid_out_d = 1'b0;
    port_out_d  = port_out_q;
    mfound_d    = mfound_q;
    midx_d      = midx_q;
    ifound_d    = ifound_q;
    iidx_d      = iidx_q;
    tbl_v_d     = tbl_v_q;
    tbl_mac_d   = tbl_mac_q;
    tbl_port_d  = tbl_port_q;
`ifdef MAC_PORT_TABLE_AGING_EN
    age_d       = age_q;
    age_cnt_d   = age_cnt_q + LGAGE'(1);
    pend_d      = pend_q | wrap_c;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.TBL_REQUEST) begin
          key_d = bus.TBL_MAC;
          if (bus.TBL_MAC[MACW-8]) begin
            port_out_d  = '1;
            valid_out_d = 1'b1;
            state_d     = S_LRESP;
          end else begin
            idx_d   = '0;
            state_d = S_LSEARCH;
          end
`ifdef MAC_PORT_TABLE_AGING_EN
        end else if (pend_q) begin
          tbl_v_d = tbl_v_q & age_q;
          age_d   = '0;
          pend_d  = wrap_c;
`endif
        end else if (bus.LEARN_VALID) begin
          if (!bus.LEARN_MAC[MACW-8] && (bus.LEARN_PORT != '0)) begin
            key_d    = bus.LEARN_MAC;
            lport_d  = bus.LEARN_PORT;
            idx_d    = '0;
            mfound_d = 1'b0;
            ifound_d = 1'b0;
            state_d  = S_WSEARCH;
          end
        end
      end
      S_LSEARCH: begin
        if (cur_hit) begin
          port_out_d  = tbl_port_q[idx_q];
          valid_out_d = 1'b1;
          state_d     = S_LRESP;
        end else if (idx_last) begin
          port_out_d  = '1;
          valid_out_d = 1'b1;
          state_d     = S_LRESP;
        end else begin
          idx_d = idx_q + LGTBL'(1);
        end
      end
      S_LRESP: state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      S_WSEARCH: begin
        if (cur_hit && !mfound_q) begin
          mfound_d = 1'b1;
          midx_d   = idx_q;
        end
        if (!tbl_v_q[idx_q] && !ifound_q) begin
          ifound_d = 1'b1;
          iidx_d   = idx_q;
        end
        if (idx_last) state_d = S_WRITE;
        else          idx_d   = idx_q + LGTBL'(1);
      end
      S_WRITE: begin
        if (mfound_q) begin
          tbl_port_d[midx_q] = lport_q;
`ifdef MAC_PORT_TABLE_AGING_EN
          age_d[midx_q] = 1'b1;
`endif
        end else if (ifound_q) begin
          tbl_v_d[iidx_q]    = 1'b1;
          tbl_mac_d[iidx_q]  = key_q;
          tbl_port_d[iidx_q] = lport_q;
`ifdef MAC_PORT_TABLE_AGING_EN
          age_d[iidx_q] = 1'b1;
`endif
        end else begin
          tbl_v_d[rr_q]    = 1'b1;
          tbl_mac_d[rr_q]  = key_q;
          tbl_port_d[rr_q] = lport_q;
          rr_d             = rr_q + LGTBL'(1);
`ifdef MAC_PORT_TABLE_AGING_EN
          age_d[rr_q] = 1'b1;
`endif
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rr_q        <= '0;
      key_q       <= '0;
      lport_q     <= '0;
      valid_out_q <= 1'b0;
      port_out_q  <= '0;
      mfound_q    <= 1'b0;
      midx_q      <= '0;
      ifound_q    <= 1'b0;
      iidx_q      <= '0;
      tbl_v_q     <= '0;
`ifdef MAC_PORT_TABLE_AGING_EN
      age_q       <= '0;
      age_cnt_q   <= '0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      key_q       <= key_d;
      lport_q     <= lport_d;
      valid_out_q <= valid_out_d;
      port_out_q  <= port_out_d;
      mfound_q    <= mfound_d;
      midx_q      <= midx_d;
      ifound_q    <= ifound_d;
      iidx_q      <= iidx_d;
      tbl_v_q     <= tbl_v_d;
`ifdef MAC_PORT_TABLE_AGING_EN
      age_q       <= age_d;
      age_cnt_q   <= age_cnt_d;
      pend_q      <= pend_d;
`endif
    end
  end

  // Entry payload storage; validity alone qualifies it, so no reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tbl_mac_q  <= tbl_mac_d;
      tbl_port_q <= tbl_port_d;
    end
  end

endmodule
